// File: rtl/pea_pkg.sv
// ============================================================================
// Module      : pea_pkg
// Description : Shared opcodes, control-token field positions, phase/mode
//               encoding and FSM states for the PEA firing controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pea_pkg;

    localparam logic [7:0] OP_STP = 8'h01;
    localparam logic [7:0] OP_EVP = 8'h02;
    localparam logic [7:0] OP_EVB = 8'h03;
    localparam logic [7:0] OP_RST = 8'h04;

    localparam int CMD_HI  = 15;
    localparam int CMD_LO  = 8;
    localparam int ARG1_HI = 7;
    localparam int ARG1_LO = 5;
    localparam int ARG2_HI = 4;
    localparam int ARG2_LO = 0;

    localparam logic [1:0] MODE_CMD  = 2'b00;
    localparam logic [1:0] MODE_COMP = 2'b01;
    localparam logic [1:0] MODE_OUT  = 2'b10;

    // S_* wait for the firing rule, B_* wait for the actor's done
    typedef enum logic [2:0] {
        S_CMD  = 3'd0,
        S_COMP = 3'd1,
        S_OUT  = 3'd2,
        B_CMD  = 3'd3,
        B_COMP = 3'd4,
        B_OUT  = 3'd5
    } state_t;

    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pea_cmd_decode.sv
// ============================================================================
// Module      : pea_cmd_decode
// Description : Combinational control-token decoder: token requirements for
//               the COMP and OUTPUT phases plus an illegal-command flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pea_cmd_decode
    import pea_pkg::*;
#(
    parameter int CONTROL_SIZE = 16,
    parameter int NUM_POLY     = 8
) (
    input  logic [CONTROL_SIZE-1:0] i_token,
    output logic [5:0]              o_data_req,
    output logic [5:0]              o_result_req,
    output logic                    o_cmd_err
);

    logic [7:0] w_op;
    logic [2:0] w_arg1;
    logic [4:0] w_arg2;
    logic       w_arg1_bad;

    assign w_op       = i_token[CMD_HI:CMD_LO];
    assign w_arg1     = i_token[ARG1_HI:ARG1_LO];
    assign w_arg2     = i_token[ARG2_HI:ARG2_LO];
    assign w_arg1_bad = ({29'd0, w_arg1} >= 32'(NUM_POLY));

    // Illegal commands request nothing so the controller can skip to OUTPUT
    always_comb begin
        o_data_req   = 6'd0;
        o_result_req = 6'd0;
        o_cmd_err    = 1'b0;
        case (w_op)
            OP_STP: begin
                if (w_arg1_bad) o_cmd_err = 1'b1;
                else            o_data_req = {1'b0, w_arg2} + 6'd1;
            end
            OP_EVP: begin
                if (w_arg1_bad) begin
                    o_cmd_err = 1'b1;
                end else begin
                    o_data_req   = 6'd1;
                    o_result_req = 6'd1;
                end
            end
            OP_EVB: begin
                if (w_arg1_bad || (w_arg2 == 5'd0)) begin
                    o_cmd_err = 1'b1;
                end else begin
                    o_data_req   = {1'b0, w_arg2};
                    o_result_req = {1'b0, w_arg2};
                end
            end
            OP_RST: begin
                o_data_req   = 6'd0;
                o_result_req = 6'd0;
            end
            default: o_cmd_err = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pea_fire_ctrl.sv
// ============================================================================
// Module      : pea_fire_ctrl
// Description : Registered firing-rule controller sequencing the PEA actor
//               through GET_COMMAND -> COMP -> OUTPUT with fire/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pea_fire_ctrl
    import pea_pkg::*;
#(
    parameter int  CONTROL_SIZE = 16,
    parameter int  BUFFER_SIZE  = 1024,
    parameter int  NUM_POLY     = 8,
    parameter int  STALL_W      = 16,
    localparam int OCC_W        = log2(BUFFER_SIZE) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OCC_W-1:0]        control_pop,
    input  logic [OCC_W-1:0]        data_pop,
    input  logic [OCC_W-1:0]        result_free_space,
    input  logic [OCC_W-1:0]        status_free_space,
    input  logic [CONTROL_SIZE-1:0] control_in,
    input  logic                    fire,
    input  logic                    done,
    output logic                    enable,
    output logic [1:0]              mode,
    output logic [CONTROL_SIZE-1:0] cmd_reg,
    output logic [5:0]              data_req,
    output logic [5:0]              result_req,
    output logic                    cmd_err,
    output logic                    proto_err,
    output logic [STALL_W-1:0]      stall_cnt
);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_enable;
    logic [CONTROL_SIZE-1:0] r_cmd_reg;
    logic [5:0]              r_data_req;
    logic [5:0]              r_result_req;
    logic                    r_cmd_err;
    logic                    r_proto_err;
    logic [STALL_W-1:0]      r_stall_cnt;

    logic [5:0]              w_dec_data_req;
    logic [5:0]              w_dec_result_req;
    logic                    w_dec_err;
    logic                    w_rule;
    logic                    w_is_wait;
    logic                    w_fire_ok;
    logic                    w_latch;
    logic                    w_skip_comp;
    logic                    w_proto;
    logic [1:0]              w_mode;

    pea_cmd_decode #(
        .CONTROL_SIZE (CONTROL_SIZE),
        .NUM_POLY     (NUM_POLY)
    ) u_cmd_decode (
        .i_token      (control_in),
        .o_data_req   (w_dec_data_req),
        .o_result_req (w_dec_result_req),
        .o_cmd_err    (w_dec_err)
    );

    // Firing rule per wait state; busy states never qualify
    always_comb begin
        w_rule    = 1'b0;
        w_is_wait = 1'b0;
        case (r_state)
            S_CMD: begin
                w_is_wait = 1'b1;
                w_rule    = (control_pop >= OCC_W'(1));
            end
            S_COMP: begin
                w_is_wait = 1'b1;
                w_rule    = (data_pop >= OCC_W'(r_data_req));
            end
            S_OUT: begin
                w_is_wait = 1'b1;
                w_rule    = (result_free_space >= OCC_W'(r_result_req)) &&
                            (status_free_space >= OCC_W'(1));
            end
            default: begin
                w_is_wait = 1'b0;
                w_rule    = 1'b0;
            end
        endcase
    end

    assign w_fire_ok = fire & r_enable;
    assign w_latch   = w_fire_ok && (r_state == S_CMD);
    assign w_proto   = (fire & ~r_enable) | (done & w_is_wait & ~w_fire_ok);

    // A fire+done in S_CMD must route on the command being latched this edge
    always_comb begin
        if (r_state == S_CMD)
            w_skip_comp = w_dec_err || (control_in[CMD_HI:CMD_LO] == OP_RST);
        else
            w_skip_comp = r_cmd_err || (r_cmd_reg[CMD_HI:CMD_LO] == OP_RST);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CMD:  if (w_fire_ok) w_next = done ? (w_skip_comp ? S_OUT : S_COMP) : B_CMD;
            S_COMP: if (w_fire_ok) w_next = done ? S_OUT : B_COMP;
            S_OUT:  if (w_fire_ok) w_next = done ? S_CMD : B_OUT;
            B_CMD:  if (done)      w_next = w_skip_comp ? S_OUT : S_COMP;
            B_COMP: if (done)      w_next = S_OUT;
            B_OUT:  if (done)      w_next = S_CMD;
            default:               w_next = S_CMD;
        endcase
    end

    always_comb begin
        case (r_state)
            S_COMP, B_COMP: w_mode = MODE_COMP;
            S_OUT,  B_OUT:  w_mode = MODE_OUT;
            default:        w_mode = MODE_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_CMD;
            r_enable     <= 1'b0;
            r_cmd_reg    <= '0;
            r_data_req   <= 6'd0;
            r_result_req <= 6'd0;
            r_cmd_err    <= 1'b0;
            r_proto_err  <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            r_state <= w_next;
            // Enable only for a state that is held; a new state re-evaluates first
            r_enable <= w_rule && (w_next == r_state);
            if (w_latch) begin
                r_cmd_reg    <= control_in;
                r_data_req   <= w_dec_data_req;
                r_result_req <= w_dec_result_req;
                r_cmd_err    <= w_dec_err;
            end
            if (w_proto) r_proto_err <= 1'b1;
            if (w_is_wait && !w_rule && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign enable     = r_enable;
    assign mode       = w_mode;
    assign cmd_reg    = r_cmd_reg;
    assign data_req   = r_data_req;
    assign result_req = r_result_req;
    assign cmd_err    = r_cmd_err;
    assign proto_err  = r_proto_err;
    assign stall_cnt  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pea_fire_ctrl.sv
// ============================================================================
// Module      : tb_pea_fire_ctrl
// Description : Directed self-checking bench for pea_fire_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pea_fire_ctrl;

    localparam int OCC_W = 11;

    logic              clk;
    logic              rst;
    logic [OCC_W-1:0]  control_pop;
    logic [OCC_W-1:0]  data_pop;
    logic [OCC_W-1:0]  result_free_space;
    logic [OCC_W-1:0]  status_free_space;
    logic [15:0]       control_in;
    logic              fire;
    logic              done;
    logic              enable;
    logic [1:0]        mode;
    logic [15:0]       cmd_reg;
    logic [5:0]        data_req;
    logic [5:0]        result_req;
    logic              cmd_err;
    logic              proto_err;
    logic [3:0]        stall_cnt;

    int r_total;
    int r_bad;

    pea_fire_ctrl #(
        .CONTROL_SIZE (16),
        .BUFFER_SIZE  (1024),
        .NUM_POLY     (8),
        .STALL_W      (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .control_pop       (control_pop),
        .data_pop          (data_pop),
        .result_free_space (result_free_space),
        .status_free_space (status_free_space),
        .control_in        (control_in),
        .fire              (fire),
        .done              (done),
        .enable            (enable),
        .mode              (mode),
        .cmd_reg           (cmd_reg),
        .data_req          (data_req),
        .result_req        (result_req),
        .cmd_err           (cmd_err),
        .proto_err         (proto_err),
        .stall_cnt         (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_total++;
        if (got !== exp) begin
            r_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        r_total = 0;
        r_bad   = 0;
        rst = 1'b0; fire = 1'b0; done = 1'b0;
        control_pop = '0; data_pop = '0; result_free_space = '0; status_free_space = '0;
        control_in = 16'h0000;
        tick(); tick();
        check_val("rst_mode",   32'(mode),       32'h0);
        check_val("rst_enable", 32'(enable),     32'h0);
        check_val("rst_cmd",    32'(cmd_reg),    32'h0);
        check_val("rst_dreq",   32'(data_req),   32'h0);
        check_val("rst_rreq",   32'(result_req), 32'h0);
        check_val("rst_err",    32'(cmd_err),    32'h0);
        check_val("rst_proto",  32'(proto_err),  32'h0);
        check_val("rst_stall",  32'(stall_cnt),  32'h0);

        // EVP arg1=2 arg2=5 via fire+done in one cycle
        rst = 1'b1; control_pop = 11'd1; control_in = 16'h0245;
        tick();
        check_val("evp_cmd_en", 32'(enable), 32'h1);
        fire = 1'b1; done = 1'b1;
        tick();
        fire = 1'b0; done = 1'b0;
        check_val("evp_mode",  32'(mode),       32'h1);
        check_val("evp_cmd",   32'(cmd_reg),    32'h0245);
        check_val("evp_dreq",  32'(data_req),   32'h1);
        check_val("evp_rreq",  32'(result_req), 32'h1);
        check_val("evp_en0",   32'(enable),     32'h0);
        tick();
        check_val("evp_wait_en",    32'(enable),    32'h0);
        check_val("evp_wait_stall", 32'(stall_cnt), 32'h1);
        data_pop = 11'd1;
        tick();
        check_val("evp_comp_en", 32'(enable),    32'h1);
        check_val("evp_stall",   32'(stall_cnt), 32'h1);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        check_val("bcomp_mode", 32'(mode),   32'h1);
        check_val("bcomp_en",   32'(enable), 32'h0);

        // Reset while busy in COMP
        rst = 1'b0; control_in = 16'h0104; data_pop = 11'd4;
        tick();
        rst = 1'b1;
        check_val("midrst_mode",  32'(mode),      32'h0);
        check_val("midrst_en",    32'(enable),    32'h0);
        check_val("midrst_stall", 32'(stall_cnt), 32'h0);
        check_val("midrst_proto", 32'(proto_err), 32'h0);
        check_val("midrst_dreq",  32'(data_req),  32'h0);

        // STP arg1=0 arg2=4 -> needs 5 data tokens
        tick();
        check_val("stp_cmd_en", 32'(enable), 32'h1);
        fire = 1'b1; done = 1'b1;
        tick();
        fire = 1'b0; done = 1'b0;
        check_val("stp_dreq", 32'(data_req),   32'h5);
        check_val("stp_rreq", 32'(result_req), 32'h0);
        tick(); tick(); tick();
        check_val("stp_short_en", 32'(enable),    32'h0);
        check_val("stp_stall3",    32'(stall_cnt), 32'h3);
        data_pop = 11'd5;
        tick();
        check_val("stp_en",     32'(enable),    32'h1);
        check_val("stp_stall",  32'(stall_cnt), 32'h3);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick(); tick();
        check_val("stp_busy_mode", 32'(mode), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check_val("stp_out_mode", 32'(mode),   32'h2);
        check_val("stp_out_en0",  32'(enable), 32'h0);
        status_free_space = 11'd1; result_free_space = 11'd0;
        tick();
        check_val("stp_out_en", 32'(enable), 32'h1);
        fire = 1'b1; done = 1'b1;
        tick();
        fire = 1'b0; done = 1'b0;
        check_val("stp_back_mode", 32'(mode),      32'h0);
        check_val("stp_proto",     32'(proto_err), 32'h0);

        // EVB arg2=0 is illegal and skips COMP
        control_in = 16'h0300;
        tick();
        fire = 1'b1; done = 1'b1; status_free_space = 11'd0;
        tick();
        fire = 1'b0; done = 1'b0;
        check_val("evb0_err",  32'(cmd_err),    32'h1);
        check_val("evb0_mode", 32'(mode),       32'h2);
        check_val("evb0_dreq", 32'(data_req),   32'h0);
        check_val("evb0_rreq", 32'(result_req), 32'h0);
        tick();
        check_val("evb0_nostat_en", 32'(enable), 32'h0);
        status_free_space = 11'd1;
        tick();
        check_val("evb0_stat_en", 32'(enable), 32'h1);
        fire = 1'b1;
        tick();
        fire = 1'b0; done = 1'b1;
        tick();
        done = 1'b0;
        check_val("evb0_done_mode", 32'(mode),    32'h0);
        check_val("evb0_err_held",  32'(cmd_err), 32'h1);

        // EVB arg1=1 arg2=3 through B_CMD, plus an early fire in COMP
        control_in = 16'h0323;
        tick();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        check_val("bcmd_mode", 32'(mode),     32'h0);
        check_val("bcmd_en",   32'(enable),   32'h0);
        check_val("evb_dreq",  32'(data_req), 32'h3);
        check_val("evb_err",   32'(cmd_err),  32'h0);
        done = 1'b1;
        tick();
        done = 1'b0; data_pop = 11'd2;
        check_val("evb_comp_mode", 32'(mode), 32'h1);
        tick();
        check_val("evb_short_en", 32'(enable), 32'h0);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        check_val("early_proto", 32'(proto_err), 32'h1);
        check_val("early_mode",  32'(mode),      32'h1);
        data_pop = 11'd3;
        tick();
        check_val("evb_comp_en", 32'(enable), 32'h1);
        fire = 1'b1;
        tick();
        fire = 1'b0; done = 1'b1;
        tick();
        done = 1'b0; result_free_space = 11'd2;
        check_val("evb_out_mode", 32'(mode), 32'h2);
        tick();
        check_val("evb_out_short_en", 32'(enable), 32'h0);
        result_free_space = 11'd3;
        tick();
        check_val("evb_out_en", 32'(enable), 32'h1);
        fire = 1'b1; done = 1'b1;
        tick();
        fire = 1'b0; done = 1'b0;

        // RST opcode: legal, skips COMP
        control_in = 16'h0400;
        tick();
        fire = 1'b1; done = 1'b1;
        tick();
        fire = 1'b0; done = 1'b0;
        check_val("rstop_mode", 32'(mode),    32'h2);
        check_val("rstop_err",  32'(cmd_err), 32'h0);
        tick();
        fire = 1'b1; done = 1'b1;
        tick();
        fire = 1'b0; done = 1'b0;

        // Unknown opcode
        control_in = 16'h0500;
        tick();
        fire = 1'b1; done = 1'b1;
        tick();
        fire = 1'b0; done = 1'b0;
        check_val("badop_mode", 32'(mode),    32'h2);
        check_val("badop_err",  32'(cmd_err), 32'h1);

        // Stall saturation and stray done
        rst = 1'b0;
        tick();
        rst = 1'b1; control_pop = 11'd0;
        repeat (20) tick();
        check_val("sat_stall", 32'(stall_cnt), 32'hF);
        check_val("sat_en",    32'(enable),    32'h0);
        check_val("sat_proto0", 32'(proto_err), 32'h0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check_val("stray_done_proto", 32'(proto_err), 32'h1);
        check_val("stray_done_mode",  32'(mode),      32'h0);

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule

`default_nettype wire
